// File: rtl/pwm_duty_ramp.sv
// Duty ramp stage ahead of the pwm block: accepts a high-side on-time target,
// clamps it to the dead-time limit and slews the live counts once per PWM period.
module pwm_duty_ramp #(
    parameter int unsigned bitwidth          = 8,
    parameter int unsigned tick_count_period = 20,
    parameter int unsigned deadtime_hs_to_ls = 3,
    parameter int unsigned deadtime_ls_to_hs = 2,
    parameter int unsigned min_on_lowside    = 1,
    parameter int unsigned ramp_step         = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                period_tick,
    input  logic                target_valid,
    output logic                target_ready,
    input  logic [bitwidth-1:0] target_highside,
    output logic [bitwidth-1:0] tick_count_highside,
    output logic [bitwidth-1:0] tick_count_lowside,
    output logic                load_enable,
    output logic                ramping,
    output logic                target_clamped
);

    localparam int unsigned W = bitwidth + 1;

    localparam logic [W-1:0] HMax = W'(tick_count_period - deadtime_hs_to_ls
                                       - deadtime_ls_to_hs - min_on_lowside);
    localparam logic [W-1:0] LsBase = W'(tick_count_period - deadtime_hs_to_ls
                                         - deadtime_ls_to_hs);
    localparam logic [W-1:0] Step = W'(ramp_step);

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_t;

    state_t              r_state;
    logic [bitwidth-1:0] r_highside;
    logic [bitwidth-1:0] r_lowside;
    logic [bitwidth-1:0] r_target;
    logic                r_load_enable;
    logic                r_ready;
    logic                r_ramping;
    logic                r_clamped;

    logic [W-1:0]        w_req_ext;
    logic                w_over;
    logic [bitwidth-1:0] w_req_clamped;
    logic [W-1:0]        w_hs_ext;
    logic [W-1:0]        w_tgt_ext;
    logic [W-1:0]        w_up_sum;
    logic [W-1:0]        w_dn_limit;
    logic [bitwidth-1:0] w_up_next;
    logic [bitwidth-1:0] w_dn_next;
    logic [bitwidth-1:0] w_hs_next;
    logic [bitwidth-1:0] w_ls_next;
    logic                w_accept;

    assign w_req_ext     = {1'b0, target_highside};
    assign w_over        = (w_req_ext > HMax);
    assign w_req_clamped = w_over ? bitwidth'(HMax) : target_highside;

    assign w_hs_ext   = {1'b0, r_highside};
    assign w_tgt_ext  = {1'b0, r_target};
    assign w_up_sum   = w_hs_ext + Step;
    assign w_dn_limit = w_tgt_ext + Step;

    // Step size 0 means jump straight to the target; otherwise saturate at it.
    assign w_up_next = ((Step == '0) || (w_up_sum >= w_tgt_ext)) ? r_target
                                                                 : bitwidth'(w_up_sum);
    assign w_dn_next = ((Step == '0) || (w_hs_ext <= w_dn_limit)) ? r_target
                                                                  : bitwidth'(w_hs_ext - Step);
    assign w_hs_next = (r_state == StRampUp) ? w_up_next : w_dn_next;
    assign w_ls_next = bitwidth'(LsBase - {1'b0, w_hs_next});

    assign w_accept = target_valid && r_ready && (r_state == StIdle);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_highside    <= '0;
            r_lowside     <= bitwidth'(LsBase);
            r_target      <= '0;
            r_load_enable <= 1'b0;
            r_ready       <= 1'b0;
            r_ramping     <= 1'b0;
            r_clamped     <= 1'b0;
        end else begin
            r_load_enable <= period_tick;
            unique case (r_state)
                StIdle: begin
                    r_ready   <= 1'b1;
                    r_ramping <= 1'b0;
                    if (w_accept) begin
                        r_target  <= w_req_clamped;
                        r_clamped <= w_over;
                        if (w_req_clamped > r_highside) begin
                            r_state   <= StRampUp;
                            r_ready   <= 1'b0;
                            r_ramping <= 1'b1;
                        end else if (w_req_clamped < r_highside) begin
                            r_state   <= StRampDown;
                            r_ready   <= 1'b0;
                            r_ramping <= 1'b1;
                        end
                    end
                end
                StRampUp, StRampDown: begin
                    r_ready   <= 1'b0;
                    r_ramping <= 1'b1;
                    if (period_tick) begin
                        r_highside <= w_hs_next;
                        r_lowside  <= w_ls_next;
                        if (w_hs_next == r_target) begin
                            r_state   <= StIdle;
                            r_ready   <= 1'b1;
                            r_ramping <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign target_ready        = r_ready;
    assign tick_count_highside = r_highside;
    assign tick_count_lowside  = r_lowside;
    assign load_enable         = r_load_enable;
    assign ramping             = r_ramping;
    assign target_clamped      = r_clamped;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with default parameters (H_MAX=14, lowside(0)=15).
module tb_pwm_duty_ramp;

    logic       clock;
    logic       reset;
    logic       period_tick;
    logic       target_valid;
    logic       target_ready;
    logic [7:0] target_highside;
    logic [7:0] tick_count_highside;
    logic [7:0] tick_count_lowside;
    logic       load_enable;
    logic       ramping;
    logic       target_clamped;

    int n_pass;
    int n_total;

    pwm_duty_ramp dut (
        .clock               (clock),
        .reset               (reset),
        .period_tick         (period_tick),
        .target_valid        (target_valid),
        .target_ready        (target_ready),
        .target_highside     (target_highside),
        .tick_count_highside (tick_count_highside),
        .tick_count_lowside  (tick_count_lowside),
        .load_enable         (load_enable),
        .ramping             (ramping),
        .target_clamped      (target_clamped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are read on the following falling edge.
    task automatic accept(input logic [7:0] value);
        target_valid    = 1'b1;
        target_highside = value;
        @(negedge clock);
        target_valid    = 1'b0;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        @(negedge clock);
        period_tick = 1'b0;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        reset           = 1'b0;
        period_tick     = 1'b0;
        target_valid    = 1'b0;
        target_highside = '0;

        // Reset held for 9 clocks, with a tick inside reset that must not load.
        repeat (8) @(negedge clock);
        tick();
        chk("rst_hs", tick_count_highside, 0);
        chk("rst_ls", tick_count_lowside, 15);
        chk("rst_le", load_enable, 0);
        chk("rst_ready", target_ready, 0);
        chk("rst_ramping", ramping, 0);
        chk("rst_clamped", target_clamped, 0);

        reset = 1'b1;
        @(negedge clock);
        chk("rel_ready", target_ready, 1);
        tick();
        chk("idle_le", load_enable, 1);
        chk("idle_hs", tick_count_highside, 0);
        chk("idle_ls", tick_count_lowside, 15);
        @(negedge clock);
        chk("idle_le_drop", load_enable, 0);

        // Ramp up 0 -> 4.
        accept(8'd4);
        chk("up_ready", target_ready, 0);
        chk("up_ramping", ramping, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("up_hs", tick_count_highside, k);
            chk("up_ls", tick_count_lowside, 15 - k);
            chk("up_le", load_enable, 1);
            chk("up_ramping_k", ramping, (k < 4) ? 1 : 0);
            chk("up_ready_k", target_ready, (k < 4) ? 0 : 1);
        end

        // Ramp down 4 -> 1.
        accept(8'd1);
        chk("dn_ramping", ramping, 1);
        for (int k = 3; k >= 1; k--) begin
            tick();
            chk("dn_hs", tick_count_highside, k);
        end
        chk("dn_ls", tick_count_lowside, 14);
        chk("dn_ready", target_ready, 1);

        accept(8'd0);
        tick();
        chk("zero_hs", tick_count_highside, 0);

        // Clamped target; a request while busy must be dropped.
        accept(8'd200);
        chk("clamp_flag", target_clamped, 1);
        target_valid    = 1'b1;
        target_highside = 8'd5;
        repeat (2) @(negedge clock);
        target_valid    = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("clamp_sum", tick_count_highside + tick_count_lowside, 15);
        end
        chk("clamp_hs", tick_count_highside, 14);
        chk("clamp_ls", tick_count_lowside, 1);
        chk("clamp_ready", target_ready, 1);
        chk("clamp_ramping", ramping, 0);
        tick();
        chk("clamp_hold", tick_count_highside, 14);

        accept(8'd0);
        chk("unclamp_flag", target_clamped, 0);
        repeat (14) tick();
        chk("unclamp_hs", tick_count_highside, 0);
        chk("unclamp_ls", tick_count_lowside, 15);

        // Target equal to live value stays idle.
        accept(8'd0);
        chk("eq_ready", target_ready, 1);
        chk("eq_ramping", ramping, 0);

        // Accept coincident with a period tick.
        target_valid    = 1'b1;
        target_highside = 8'd2;
        period_tick     = 1'b1;
        @(negedge clock);
        target_valid    = 1'b0;
        period_tick     = 1'b0;
        chk("co_le", load_enable, 1);
        chk("co_hs", tick_count_highside, 0);
        chk("co_ls", tick_count_lowside, 15);
        chk("co_ramping", ramping, 1);
        tick();
        chk("co_hs1", tick_count_highside, 1);
        chk("co_ls1", tick_count_lowside, 14);
        tick();
        chk("co_hs2", tick_count_highside, 2);
        chk("co_idle", ramping, 0);

        // Reset mid-ramp at highside 2, checked before any clock edge.
        accept(8'd0);
        repeat (2) tick();
        accept(8'd5);
        repeat (2) tick();
        chk("mid_hs", tick_count_highside, 2);
        chk("mid_ramping", ramping, 1);
        reset = 1'b0;
        #1;
        chk("arst_hs", tick_count_highside, 0);
        chk("arst_ls", tick_count_lowside, 15);
        chk("arst_ramping", ramping, 0);
        chk("arst_ready", target_ready, 0);
        chk("arst_le", load_enable, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rel2_ready", target_ready, 1);
        chk("rel2_hs", tick_count_highside, 0);
        accept(8'd3);
        repeat (3) tick();
        chk("post_hs", tick_count_highside, 3);
        chk("post_ls", tick_count_lowside, 12);
        chk("post_ready", target_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Upstream stage of the pwm block. Accepts a target high-side on-time over a valid/ready handshake, clamps it to what the dead-times allow, and slews the live value toward it by a fixed step once per PWM period. It drives the pwm block's tick_count_highside, tick_count_lowside and load_enable inputs. The period strobe comes from the counter block's overflow output.

Parameters:
bitwidth, 8, width of all tick-count values
tick_count_period, 20, PWM period in ticks (P)
deadtime_hs_to_ls, 3, dead-time after high-side in ticks (D1)
deadtime_ls_to_hs, 2, dead-time after low-side in ticks (D2)
min_on_lowside, 1, minimum low-side on-time in ticks (M)
ramp_step, 1, ticks added or removed per period; 0 = jump directly to target

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
period_tick  input  1  one-cycle strobe per PWM period (counter overflow)
target_valid  input  1  target_highside is valid
target_ready  output  1  block can accept a new target
target_highside  input  bitwidth  requested high-side on-time in ticks
tick_count_highside  output  bitwidth  live high-side on-time to pwm
tick_count_lowside  output  bitwidth  live low-side on-time to pwm
load_enable  output  1  one-cycle strobe; pwm latches the two counts
ramping  output  1  high while not at target
target_clamped  output  1  last accepted target exceeded H_MAX

Behaviour:
- Derived constants: H_MAX = P-D1-D2-M; lowside = P-D1-D2-highside. With defaults, H_MAX=14 and lowside(0)=15. Evaluate arithmetic in bitwidth+1 bits.
- Reset (asynchronous, while reset=0) sets:
  - highside=0, lowside=P-D1-D2, target register=0
  - load_enable=0, target_ready=0, ramping=0, target_clamped=0
  - state IDLE
- All outputs are registered.
- State IDLE:
  - target_ready=1 from the first clock edge after reset release.
  - Accept occurs when target_valid and target_ready are both high at a clock edge.
  - On accept: target register = min(target_highside, H_MAX); target_clamped = (target_highside > H_MAX).
  - Next state is RAMP_UP if the clamped target > highside, RAMP_DOWN if it is < highside, otherwise IDLE.
  - target_ready=0 in the cycle after an accept that leaves IDLE.
- State RAMP_UP / RAMP_DOWN:
  - target_ready=0 and ramping=1.
  - On each period_tick: highside moves toward the target by ramp_step, saturating at the target. ramp_step=0 reaches the target in one tick.
  - lowside is recomputed on the same edge.
  - On the edge where highside reaches the target: state -> IDLE, ramping=0, target_ready=1.
- load_enable:
  - Registered copy of period_tick, so it rises one cycle after the tick, in every state.
  - highside and lowside are already stable when load_enable=1.
  - Values never change while load_enable=1.
- Accept and period_tick on the same edge in IDLE: the tick reloads the unchanged values; the first ramp step occurs on the next period_tick.
- target_valid while target_ready=0 is ignored; no buffering.
- Invariants at all times: highside ≤ H_MAX, lowside ≥ M, highside+lowside+D1+D2 = P.
- Reset asserted mid-ramp: all outputs return to their reset values immediately; any pending target is discarded.

Test Plan:
1. Hold reset=0 for 9 clocks -> highside=0, lowside=15, load_enable=0, target_ready=0. Release reset -> target_ready=1 after one edge; each period_tick gives a load_enable pulse with 0/15.
2. Accept target 4 -> target_ready=0 and ramping=1. Highside goes 1,2,3,4 over 4 period_ticks, lowside goes 14,13,12,11, one load_enable per tick. On the 4th tick edge: ramping=0, target_ready=1.
3. Accept target 200 from highside 0 -> target_clamped=1; after 14 ticks highside=14, lowside=1.
4. From highside 4, accept target 1 -> RAMP_DOWN; highside goes 3,2,1 over 3 ticks, lowside ends at 14.
5. Accept target 2 on the same edge as period_tick from highside 0 -> the load_enable pulse carries 0/15; highside=1 only after the next tick.
6. Assert reset=0 mid-ramp at highside=2 -> highside=0, lowside=15, ramping=0, target_ready=0 with no clock edge needed. After release the block is in IDLE and accepts a new target.
